// File: rtl/otter_ctrl_fsm.sv
// ============================================================================
// otter_ctrl_fsm
// ----------------------------------------------------------------------------
// Multicycle control unit for the OTTER RV32I core (no CSR / interrupt
// support). It steps each instruction through FETCH -> EXEC and, for loads
// only, WRITEBACK. It decodes the instruction register and drives every
// select and enable input of the datapath (PC_MOD, register file, ALU and
// memory). The PC is loaded exactly once per instruction, in that
// instruction's last cycle.
//
// Parameters
//   HALT_ON_ILLEGAL  1: an unsupported opcode or funct3 parks the FSM in HALT
//                    0: an unsupported instruction behaves as a NOP
//
// Ports
//   clk        in   1   system clock, all state changes on posedge
//   rst        in   1   synchronous active-high reset; all outputs 0 while high
//   ir         in   32  current instruction (valid from EXEC onward)
//   br_eq      in   1   rs1 == rs2
//   br_lt      in   1   rs1 <  rs2 (signed)
//   br_ltu     in   1   rs1 <  rs2 (unsigned)
//   pcWrite    out  1   PC load enable
//   pcSource   out  2   0 PC+4, 1 jalr, 2 branch, 3 jal
//   regWrite   out  1   register file write enable
//   rf_wr_sel  out  2   0 PC+4, 1 reserved, 2 mem dout2, 3 ALU result
//   memRDEN1   out  1   instruction fetch read enable
//   memRDEN2   out  1   data read enable
//   memWE2     out  1   data write enable
//   alu_fun    out  4   {funct7[5], funct3}; 0000 add, 1001 lui-copy
//   srcA_sel   out  1   0 rs1, 1 U-immediate
//   srcB_sel   out  3   0 rs2, 1 I-imm, 2 S-imm, 3 PC
//   halted     out  1   high while the FSM sits in HALT
// ============================================================================
module otter_ctrl_fsm #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ir,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic        br_ltu,
    output logic        pcWrite,
    output logic [1:0]  pcSource,
    output logic        regWrite,
    output logic [1:0]  rf_wr_sel,
    output logic        memRDEN1,
    output logic        memRDEN2,
    output logic        memWE2,
    output logic [3:0]  alu_fun,
    output logic        srcA_sel,
    output logic [2:0]  srcB_sel,
    output logic        halted
);

    // Controller states
    localparam logic [1:0] ST_FETCH     = 2'd0;
    localparam logic [1:0] ST_EXEC      = 2'd1;
    localparam logic [1:0] ST_WRITEBACK = 2'd2;
    localparam logic [1:0] ST_HALT      = 2'd3;

    // RV32I base opcodes
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // pcSource encodings
    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_JALR   = 2'd1;
    localparam logic [1:0] PC_BRANCH = 2'd2;
    localparam logic [1:0] PC_JAL    = 2'd3;

    // rf_wr_sel encodings
    localparam logic [1:0] WR_PC4    = 2'd0;
    localparam logic [1:0] WR_MEM    = 2'd2;
    localparam logic [1:0] WR_ALU    = 2'd3;

    // srcB_sel encodings
    localparam logic [2:0] SRCB_RS2  = 3'd0;
    localparam logic [2:0] SRCB_IIMM = 3'd1;
    localparam logic [2:0] SRCB_SIMM = 3'd2;
    localparam logic [2:0] SRCB_PC   = 3'd3;

    // ALU function codes used directly by the controller
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_LUI   = 4'b1001;

    logic [1:0] state;
    logic [1:0] next_state;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       is_legal;
    logic       branch_taken;
    logic       unused_ir_bits;

    assign opcode    = ir[6:0];
    assign funct3    = ir[14:12];
    assign funct7_b5 = ir[30];

    // Register numbers and immediates are consumed by the datapath, not here.
    assign unused_ir_bits = ^{ir[31], ir[29:15], ir[11:7]};

    // State register. Reset always lands in FETCH, even mid-load, so an
    // interrupted load never completes its register write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Legality check. Beyond unknown opcodes, funct3 values that RV32I leaves
    // undefined for JALR, branches, loads and stores are rejected so they
    // can't silently become a memory access or a jump.
    always_comb begin
        is_legal = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_IMM, OP_REG: is_legal = 1'b1;
            OP_JALR:   is_legal = (funct3 == 3'b000);
            OP_BRANCH: is_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            OP_LOAD:   is_legal = (funct3 != 3'b011) && (funct3 != 3'b110)
                                  && (funct3 != 3'b111);
            OP_STORE:  is_legal = (funct3 == 3'b000) || (funct3 == 3'b001)
                                  || (funct3 == 3'b010);
            default:   is_legal = 1'b0;
        endcase
    end

    // Branch condition. funct3[0] inverts the base comparison picked by
    // funct3[2:1] (eq, lt, ltu); the illegal 01x codes never reach here
    // because they fail the legality check.
    always_comb begin
        branch_taken = 1'b0;
        case (funct3[2:1])
            2'b00:   branch_taken = br_eq  ^ funct3[0];
            2'b10:   branch_taken = br_lt  ^ funct3[0];
            2'b11:   branch_taken = br_ltu ^ funct3[0];
            default: branch_taken = 1'b0;
        endcase
    end

    // Output and next-state decode. Everything defaults to 0 and only the
    // strobes an instruction needs are raised. While rst is high the whole
    // block is skipped so every output reads 0.
    always_comb begin
        next_state = state;
        pcWrite    = 1'b0;
        pcSource   = PC_PLUS4;
        regWrite   = 1'b0;
        rf_wr_sel  = WR_PC4;
        memRDEN1   = 1'b0;
        memRDEN2   = 1'b0;
        memWE2     = 1'b0;
        alu_fun    = ALU_ADD;
        srcA_sel   = 1'b0;
        srcB_sel   = SRCB_RS2;
        halted     = 1'b0;

        if (!rst) begin
            case (state)
                ST_FETCH: begin
                    memRDEN1   = 1'b1;
                    next_state = ST_EXEC;
                end

                ST_EXEC: begin
                    if (!is_legal) begin
                        if (HALT_ON_ILLEGAL) begin
                            next_state = ST_HALT;
                        end else begin
                            pcWrite    = 1'b1;
                            next_state = ST_FETCH;
                        end
                    end else begin
                        // Every legal instruction except a load finishes here.
                        pcWrite    = 1'b1;
                        next_state = ST_FETCH;
                        case (opcode)
                            OP_LUI: begin
                                regWrite  = 1'b1;
                                rf_wr_sel = WR_ALU;
                                srcA_sel  = 1'b1;
                                alu_fun   = ALU_LUI;
                            end
                            OP_AUIPC: begin
                                regWrite  = 1'b1;
                                rf_wr_sel = WR_ALU;
                                srcA_sel  = 1'b1;
                                srcB_sel  = SRCB_PC;
                            end
                            OP_JAL: begin
                                regWrite  = 1'b1;
                                rf_wr_sel = WR_PC4;
                                pcSource  = PC_JAL;
                            end
                            OP_JALR: begin
                                regWrite  = 1'b1;
                                rf_wr_sel = WR_PC4;
                                pcSource  = PC_JALR;
                            end
                            OP_BRANCH: begin
                                pcSource = branch_taken ? PC_BRANCH : PC_PLUS4;
                            end
                            OP_LOAD: begin
                                // The address is formed now; the PC waits for
                                // WRITEBACK so it still updates only once.
                                memRDEN2   = 1'b1;
                                srcB_sel   = SRCB_IIMM;
                                pcWrite    = 1'b0;
                                next_state = ST_WRITEBACK;
                            end
                            OP_STORE: begin
                                memWE2   = 1'b1;
                                srcB_sel = SRCB_SIMM;
                            end
                            OP_IMM: begin
                                // Only the shift-right immediates use ir[30]
                                // to choose srai over srli; in every other
                                // OP-IMM it is immediate data.
                                regWrite  = 1'b1;
                                rf_wr_sel = WR_ALU;
                                srcB_sel  = SRCB_IIMM;
                                alu_fun   = {(funct3 == 3'b101) ? funct7_b5 : 1'b0, funct3};
                            end
                            OP_REG: begin
                                regWrite  = 1'b1;
                                rf_wr_sel = WR_ALU;
                                srcB_sel  = SRCB_RS2;
                                alu_fun   = {funct7_b5, funct3};
                            end
                            default: begin
                                pcWrite = 1'b1;
                            end
                        endcase
                    end
                end

                ST_WRITEBACK: begin
                    // The read enable stays high so the data memory output
                    // is still valid while the register file captures it.
                    memRDEN2   = 1'b1;
                    regWrite   = 1'b1;
                    rf_wr_sel  = WR_MEM;
                    pcWrite    = 1'b1;
                    next_state = ST_FETCH;
                end

                ST_HALT: begin
                    halted     = 1'b1;
                    next_state = ST_HALT;
                end

                default: begin
                    next_state = ST_FETCH;
                end
            endcase
        end
    end

endmodule
